// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared constants and state type for the writeback stage
package writeback_pkg;
    localparam int WSEL_REG  = 1;
    localparam int WSEL_PC   = 2;
    localparam int WSEL_OUT  = 3;
    localparam int REG_IDX_W = 5;
    localparam int REG_COUNT = 1 << REG_IDX_W;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_OUT = 1'b1
    } wb_state_t;
endpackage

// File: rtl/writeback_byte_fifo.sv
// rtl/writeback_byte_fifo.sv - byte FIFO for the OUT port; full/empty judged on registered occupancy
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic [7:0]                 head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    // Push is refused when full even if a pop happens in the same cycle.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/writeback.sv
// rtl/writeback.sv - register file, PC and OUT retirement; WRITEBACK_BYPASS_EN forwards same-cycle writes to read ports
module writeback
    import writeback_pkg::*;
#(
    parameter int          OUT_DEPTH = 16,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enable,
    input  logic [3:0]                  wselector,
    input  logic [31:0]                 data,
    input  logic [REG_IDX_W-1:0]        rd_in,
    input  logic [31:0]                 pc_in,
    input  logic [REG_IDX_W-1:0]        rs_addr,
    input  logic [REG_IDX_W-1:0]        rt_addr,
    output logic [31:0]                 rs_data,
    output logic [31:0]                 rt_data,
    output logic [31:0]                 pc,
    output logic                        done,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(OUT_DEPTH):0]  out_count
);
    wb_state_t   r_state;
    wb_state_t   w_state_nxt;
    logic [31:0] r_regs [REG_COUNT];
    logic [31:0] r_pc;
    logic        r_done;
    logic [7:0]  r_out_byte;

    logic        w_retire;
    logic        w_reg_we;
    logic        w_push;
    logic [7:0]  w_push_data;
    logic        w_latch;
    logic        w_done_nxt;
    logic        w_full;
    logic        w_empty;
    logic        w_unused;

    assign w_unused = wselector[0];
    assign w_retire = (r_state == S_IDLE) && enable;
    assign w_reg_we = w_retire && wselector[WSEL_REG] && (rd_in != '0);

`ifdef WRITEBACK_BYPASS_EN
    assign rs_data = (w_reg_we && rd_in == rs_addr) ? data : r_regs[rs_addr];
    assign rt_data = (w_reg_we && rd_in == rt_addr) ? data : r_regs[rt_addr];
`else
    assign rs_data = r_regs[rs_addr];
    assign rt_data = r_regs[rt_addr];
`endif

    assign pc        = r_pc;
    assign done      = r_done;
    assign out_valid = !w_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = data[7:0];
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    if (wselector[WSEL_OUT]) begin
                        if (!w_full) begin
                            w_push     = 1'b1;
                            w_done_nxt = 1'b1;
                        end else begin
                            w_latch     = 1'b1;
                            w_state_nxt = S_WAIT_OUT;
                        end
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_WAIT_OUT: begin
                // Incoming enable is ignored here; only the held byte matters.
                w_push_data = r_out_byte;
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_done     <= 1'b0;
            r_out_byte <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_retire) begin
                r_pc <= wselector[WSEL_PC] ? pc_in : r_pc + 32'd4;
            end
            if (w_latch) begin
                r_out_byte <= data[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_reg_we) begin
            r_regs[rd_in] <= data;
        end
    end

    byte_fifo #(
        .DEPTH(OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (out_ready),
        .head_data (out_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (out_count)
    );
endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - directed self-checking bench for writeback
module tb_writeback;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [3:0]  wselector;
    logic [31:0] data;
    logic [4:0]  rd_in;
    logic [31:0] pc_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc;
    logic        done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    writeback #(
        .OUT_DEPTH (DEPTH),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .wselector (wselector),
        .data      (data),
        .rd_in     (rd_in),
        .pc_in     (pc_in),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .pc        (pc),
        .done      (done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [3:0] ws, input logic [4:0] rd,
                          input logic [31:0] d, input logic [31:0] tgt);
        enable    = 1'b1;
        wselector = ws;
        rd_in     = rd;
        data      = d;
        pc_in     = tgt;
        tick();
        enable    = 1'b0;
        wselector = 4'b0000;
    endtask

    logic [31:0] exp_byp;

    initial begin
        rstn = 1'b0; enable = 1'b0; wselector = '0; data = '0; rd_in = '0;
        pc_in = '0; rs_addr = '0; rt_addr = '0; out_ready = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_count", {27'd0, out_count}, 32'd0);

        rs_addr = 5'd5;
        retire(4'b0010, 5'd5, 32'hDEAD_BEEF, 32'h0);
        chk("w5_rs", rs_data, 32'hDEAD_BEEF);
        chk("w5_pc", pc, RST_PC + 32'd4);
        chk("w5_done", {31'd0, done}, 32'd1);
        tick();
        chk("done_pulse", {31'd0, done}, 32'd0);

        rt_addr = 5'd31;
        retire(4'b0110, 5'd31, 32'h0000_0104, 32'h0000_0200);
        chk("w31_rt", rt_data, 32'h0000_0104);
        chk("w31_pc", pc, 32'h0000_0200);
        chk("w31_done", {31'd0, done}, 32'd1);

        rs_addr = 5'd0;
        retire(4'b0010, 5'd0, 32'h0000_1234, 32'h0);
        chk("r0_zero", rs_data, 32'h0);
        chk("r0_pc", pc, 32'h0000_0204);

        retire(4'b0100, 5'd0, 32'h0, 32'hFFFF_FFFC);
        chk("pc_jump", pc, 32'hFFFF_FFFC);
        retire(4'b0000, 5'd0, 32'h0, 32'h0);
        chk("pc_wrap", pc, 32'h0000_0000);

        // Same-cycle read of a register being written
        rs_addr = 5'd7; enable = 1'b1; wselector = 4'b0010; rd_in = 5'd7; data = 32'h55;
`ifdef WRITEBACK_BYPASS_EN
        exp_byp = 32'h55;
`else
        exp_byp = 32'h0;
`endif
        #2;
        chk("bypass", rs_data, exp_byp);
        tick();
        enable = 1'b0; wselector = '0;
        chk("r7_after", rs_data, 32'h55);

        // Fill the OUT FIFO with 'A'..'P' while the consumer stalls
        for (int i = 0; i < DEPTH; i++) begin
            retire(4'b1000, 5'd0, 32'h41 + i, 32'h0);
            chk("fill_done", {31'd0, done}, 32'd1);
        end
        chk("full_count", {27'd0, out_count}, 32'd16);
        chk("full_head", {24'd0, out_data}, 32'h41);
        tick();
        chk("stall_head", {24'd0, out_data}, 32'h41);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);

        retire(4'b1000, 5'd0, 32'h51, 32'h0);
        chk("q_withheld", {31'd0, done}, 32'd0);
        chk("q_count", {27'd0, out_count}, 32'd16);
        tick();
        chk("q_wait", {31'd0, done}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_count", {27'd0, out_count}, 32'd15);
        chk("pop_head", {24'd0, out_data}, 32'h42);
        chk("pop_nodone", {31'd0, done}, 32'd0);
        tick();
        chk("q_count2", {27'd0, out_count}, 32'd16);
        chk("q_done", {31'd0, done}, 32'd1);
        tick();
        chk("q_done_pulse", {31'd0, done}, 32'd0);

        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_data", {24'd0, out_data}, 32'h42 + i);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_count", {27'd0, out_count}, 32'd0);
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop keeps occupancy
        retire(4'b1000, 5'd0, 32'h61, 32'h0);
        out_ready = 1'b1;
        retire(4'b1000, 5'd0, 32'h62, 32'h0);
        out_ready = 1'b0;
        chk("pp_count", {27'd0, out_count}, 32'd1);
        chk("pp_head", {24'd0, out_data}, 32'h62);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pp_empty", {27'd0, out_count}, 32'd0);

        // Reset while waiting on a full FIFO
        for (int i = 0; i < DEPTH + 1; i++) begin
            retire(4'b1000, 5'd0, 32'h30 + i, 32'h0);
        end
        chk("wait_nodone", {31'd0, done}, 32'd0);
        rstn = 1'b0;
        tick();
        chk("wr_valid", {31'd0, out_valid}, 32'd0);
        chk("wr_count", {27'd0, out_count}, 32'd0);
        chk("wr_pc", pc, RST_PC);
        chk("wr_done", {31'd0, done}, 32'd0);
        rstn = 1'b1;
        rs_addr = 5'd5;
        tick();
        chk("wr_done2", {31'd0, done}, 32'd0);
        chk("wr_count2", {27'd0, out_count}, 32'd0);
        chk("wr_regclr", rs_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
